// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM
// state type, default address window and a size helper.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 behaves as a word too

    localparam int LSU_BASE_ADDR  = 1024;
    localparam int LSU_LIMIT_ADDR = 1280;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Byte and halfword sizes have bit 1 clear; both word encodings have it set.
    function automatic logic is_subword(input logic [1:0] size);
        return (size & SZ_WORD) == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit: extracts and extends
// sub-word load data from the fetched word, and merges sub-word store data
// into that word for the read-modify-write. Lanes are little-endian.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then extend for loads / splice for stores.
    always_comb begin
        byte_sel     = word_i[{offset_i, 3'b000} +: 8];
        half_sel     = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o  = word_i;
        store_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o  = {{24{signed_i & byte_sel[7]}}, byte_sel};
                store_data_o = word_i;
                store_data_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_o  = {{16{signed_i & half_sel[15]}}, half_sel};
                store_data_o = word_i;
                store_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-wide data memory. Takes one
// byte/half/word request at a time, uses read-modify-write for sub-word
// stores and returns a one-cycle response pulse.
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so the pipeline
// stalls until the response pulse has been issued.
// Optional macro LSU_FAULT_EN: raise resp_fault for misaligned or
// out-of-window requests instead of silently aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int BASE_ADDR  = LSU_BASE_ADDR,
    parameter int LIMIT_ADDR = LSU_LIMIT_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    input  logic [31:0]       mem_out,
    output lsu_state_e        dbg_state
);

    lsu_state_e        state_q, state_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic              fault_q;
    logic              accept;
    logic              acc_fault;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign dbg_state = state_q;

`ifdef LSU_FAULT_EN
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(LIMIT_ADDR);

    logic [ADDR_W-1:0] req_aligned;
    logic              misalign;
    logic              out_of_range;

    assign req_aligned  = {req_addr[ADDR_W-1:2], 2'b00};
    assign misalign     = ((req_size == SZ_HALF) && req_addr[0]) ||
                          (!is_subword(req_size) && (req_addr[1:0] != 2'b00));
    assign out_of_range = (req_addr < BASE_A) || (req_aligned > LIMIT_A);
    assign acc_fault    = misalign || out_of_range;
`else
    // The address window only matters when faults are enabled.
    logic unused_cfg;
    assign unused_cfg = ^{BASE_ADDR, LIMIT_ADDR};
    assign acc_fault  = 1'b0;
`endif

    // State register; reset drops straight to IDLE, abandoning any store.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Request capture on accept, and memory word capture during RD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            word_q   <= '0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                fault_q  <= acc_fault;
            end
            if (state_q == ST_RD) word_q <= mem_out;
        end
    end

    // Next-state: word stores skip the read, faults skip memory entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (acc_fault)                                  state_d = ST_RESP;
                    else if (req_write && !is_subword(req_size))    state_d = ST_WR;
                    else                                            state_d = ST_RD;
                end
            end
            ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .word_i       (word_q),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .offset_i     (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    // Outputs decoded from state so reset removes mem_write immediately.
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        mem_write   = (state_q == ST_WR);
        mem_address = {addr_q[ADDR_W-1:2], 2'b00};
        mem_data    = '0;
        resp_valid  = (state_q == ST_RESP);
        resp_rdata  = '0;
        resp_fault  = 1'b0;
        if (state_q == ST_WR) mem_data = store_data;
        if (state_q == ST_RESP) begin
            resp_fault = fault_q;
            if (!write_q && !fault_q) resp_rdata = load_data;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the processor memory stage and drives the word-wide data memory (synchronous write, combinational read of the word-aligned address).
- Provides byte/halfword/word access:
  - sub-word loads are extracted from the aligned word;
  - sub-word stores use read-modify-write.
- Stalls the pipeline through req_ready until the response is issued.

Parameters:
- ADDR_W, 11, byte address width (matches data memory).
- BASE_ADDR, 1024, lowest valid address.
- LIMIT_ADDR, 1280, highest valid address (inclusive).

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when req_valid&req_ready.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified for sub-word.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_rdata  out  32  load result (0 for stores).
- resp_fault  out  1  fault flag, valid with resp_valid.
- mem_write  out  1  data memory write enable.
- mem_address  out  ADDR_W  data memory address, always {addr[ADDR_W-1:2],2'b00}.
- mem_data  out  32  data memory write data.
- mem_out  in  32  data memory read data (combinational on mem_address).

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_write=0, mem_address=0, mem_data=0, state=IDLE.
- Request fields are registered on acceptance; inputs are ignored outside IDLE.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On accept:
  - load -> RD;
  - word store -> WR;
  - byte/half store -> RD.
- RD: mem_write=0, mem_address=aligned address. Register mem_out into word_q at the rising edge.
  - load -> RESP;
  - sub-word store -> WR.
- WR: mem_write=1 for exactly one cycle.
  - mem_data = req_wdata for word stores;
  - otherwise mem_data = word_q with the selected lane replaced.
  - -> RESP.
- RESP: resp_valid=1 for one cycle.
  - loads: resp_rdata = extracted value;
  - stores: resp_rdata = 0.
  - -> IDLE. req_ready returns to 1 in the following cycle.
- Latency, counted from the accept edge:
  - load: resp_valid in cycle 2;
  - word store: resp_valid in cycle 2;
  - sub-word store: resp_valid in cycle 3.
  - Throughput is one request per 3 (4) cycles.
- Lanes are little-endian:
  - byte: addr[1:0]=0 selects bits 7:0, ..., 3 selects bits 31:24;
  - half: addr[1]=0 selects bits 15:0, addr[1]=1 selects bits 31:16.
- Extension: sub-word loads are zero-extended unless req_signed=1 (sign-extended).
- Without the optional feature, low address bits that are illegal for the size are ignored:
  - half uses addr[1] only;
  - word forces addr[1:0]=0.
- Reset asserted mid-operation: immediate return to IDLE, mem_write drops asynchronously, and the pending store is abandoned (no partial write).
- req_valid held high in RESP: not accepted until IDLE.
- mem_write is never asserted outside WR.

Optional Feature:
- Macro: LSU_FAULT_EN.
- With the macro, a fault is raised on accept when either condition holds:
  - misalignment: half with addr[0]=1, or word with addr[1:0]!=0;
  - range: addr < BASE_ADDR or aligned addr > LIMIT_ADDR.
- Fault handling: IDLE -> RESP directly, no memory access, resp_fault=1, resp_rdata=0.
- Without the macro, resp_fault is constant 0 and the alignment is forced as above.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - BASE/LIMIT constants.
- One natural sub-module, lsu_lane_align (combinational):
  - load extract/extend from word_q;
  - store merge of wdata into word_q.

Test Plan:
- Load word 1024, memory word holds 200 -> resp_valid in cycle 2, rdata=200, no mem_write.
- Memory 1028 = 0x80FF1234; signed byte load @1029 -> 0x00000012; @1031 signed -> 0xFFFFFF80; unsigned half @1030 -> 0x000080FF.
- Byte store 0xAB @1030 over 0x80FF1234 -> one mem_write cycle at 1028 with data 0x80AB1234, resp_valid in cycle 3.
- Word store 9 @1032 then word load @1032 -> read returns 9; mem_write high exactly one cycle.
- Reset pulse during WR of a sub-word store -> mem_write drops at once, req_ready=1 after reset, memory word unchanged.
- LSU_FAULT_EN: word load @1026 or @1284 -> resp_fault=1, rdata=0, no memory access; without the macro, load @1026 returns the word at 1024.
